// File: rtl/fm_nco.sv
// FM numerically controlled oscillator: audio-modulated phase increment,
// wrapping phase accumulator and optionally dithered, truncated phase output.
module fm_nco #(
  parameter int          A         = 8,
  parameter int          K         = 4,
  parameter int          L         = 2,
  parameter int          N         = 18,
  parameter int          M         = 14,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [A-1:0] audio,
  input  logic         audio_valid,
  input  logic [N-1:0] acc_inc,
  input  logic [K-1:0] df_inc_coef,
  input  logic [L-1:0] df_inc_fact,
  input  logic [2:0]   dith_fact,
  output logic [N-1:0] freq_inc,
  output logic [M-1:0] phase,
  output logic         wrap
);

  logic [A-1:0] audio_hold_q;
  logic [N-1:0] freq_inc_q, freq_inc_d;
  logic [N-1:0] phase_acc_q, phase_acc_d;
  logic [M-1:0] phase_q, phase_d;
  logic         wrap_q, wrap_d;
  logic [15:0]  lfsr_q, lfsr_d;

  logic [N-1:0] aud_ext;
  logic [N-1:0] coef_ext;
  logic [N-1:0] dev;
  logic [3:0]   shamt;
  logic [N:0]   acc_sum;
  logic [15:0]  dith_mask;
  logic [N-1:0] dith_ext;
  logic [N-1:0] phase_sum;

  // Unsigned modulo-2^N product of the sign-extended sample equals the
  // two's complement product, so no signed arithmetic is needed.
  assign aud_ext    = {{(N-A){audio_hold_q[A-1]}}, audio_hold_q};
  assign coef_ext   = N'(df_inc_coef);
  assign shamt      = 4'(df_inc_fact) + 4'd5;
  assign dev        = (aud_ext * coef_ext) << shamt;
  assign freq_inc_d = acc_inc + dev;

  assign acc_sum     = {1'b0, phase_acc_q} + {1'b0, freq_inc_q};
  assign phase_acc_d = acc_sum[N-1:0];
  assign wrap_d      = acc_sum[N];

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Dither add wraps silently; it never contributes to wrap.
  assign dith_mask = (16'd1 << dith_fact) - 16'd1;
  assign dith_ext  = N'(lfsr_q & dith_mask);
  assign phase_sum = phase_acc_q + dith_ext;
  assign phase_d   = phase_sum[N-1:N-M];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      audio_hold_q <= '0;
      freq_inc_q   <= '0;
      phase_acc_q  <= '0;
      phase_q      <= '0;
      wrap_q       <= 1'b0;
      lfsr_q       <= LFSR_SEED;
    end else begin
      if (audio_valid) audio_hold_q <= audio;
      freq_inc_q <= freq_inc_d;
      if (en) begin
        phase_acc_q <= phase_acc_d;
        wrap_q      <= wrap_d;
        lfsr_q      <= lfsr_d;
        phase_q     <= phase_d;
      end else begin
        wrap_q <= 1'b0;
      end
    end
  end

  assign freq_inc = freq_inc_q;
  assign phase    = phase_q;
  assign wrap     = wrap_q;

endmodule
